// File: rtl/clk_divider_prog.sv
// Runtime-programmable clock/tick generator: square or pulse output with a
// period-start tick, divisor changes deferred to period boundaries.
module clk_divider_prog #(
  parameter int unsigned WIDTH       = 27,
  parameter int unsigned DEFAULT_DIV = 125_000_000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic             pending,
  output logic [WIDTH-1:0] div_active
);

  localparam logic [WIDTH-1:0] DIV_MIN   = WIDTH'(2);
  localparam logic [WIDTH-1:0] DIV_RESET = (DEFAULT_DIV < 2) ? DIV_MIN : WIDTH'(DEFAULT_DIV);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_flag_q, pend_flag_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] high_len;
  logic [WIDTH-1:0] last_cnt;
  logic [WIDTH-1:0] cnt_inc;

  always_comb begin
    high_len = mode ? WIDTH'(1) : (div_act_q >> 1);
    last_cnt = div_act_q - WIDTH'(1);
    cnt_inc  = cnt_q + WIDTH'(1);

    state_d     = state_q;
    cnt_d       = cnt_q;
    div_act_d   = div_act_q;
    div_pend_d  = div_pend_q;
    pend_flag_d = pend_flag_q;
    clk_out_d   = 1'b0;
    tick_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          if (pend_flag_q) begin
            div_act_d   = div_pend_q;
            pend_flag_d = 1'b0;
          end
          state_d   = ST_RUN;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt_q == last_cnt) begin
          cnt_d = '0;
          if (pend_flag_q) begin
            div_act_d   = div_pend_q;
            pend_flag_d = 1'b0;
          end
          if (enable) begin
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d     = cnt_inc;
          clk_out_d = (cnt_inc < high_len);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A load coinciding with a boundary lands after the swap above, so it
    // stays pending for the following boundary.
    if (load) begin
      div_pend_d  = clamp_div(div_val);
      pend_flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      div_act_q   <= DIV_RESET;
      div_pend_q  <= DIV_RESET;
      pend_flag_q <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_act_q   <= div_act_d;
      div_pend_q  <= div_pend_d;
      pend_flag_q <= pend_flag_d;
      clk_out_q   <= clk_out_d;
      tick_q      <= tick_d;
    end
  end

  assign clk_out    = clk_out_q;
  assign tick       = tick_q;
  assign pending    = pend_flag_q;
  assign div_active = div_act_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog: period-level reference model checked every
// cycle, plus directed waveform patterns with literal expectations.
module tb_clk_divider_prog;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         mode = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] div_val = '0;
  logic         clk_out, tick, pending;
  logic [W-1:0] div_active;

  int checks = 0;
  int failures = 0;

  clk_divider_prog #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .clk_in(clk), .reset(rst), .enable(en), .mode(mode), .load(load),
    .div_val(div_val), .clk_out(clk_out), .tick(tick), .pending(pending),
    .div_active(div_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks which cycle of the current period we are in.
  int unsigned m_len = 4, m_pos = 0, m_pend = 0;
  bit m_run = 0, m_pflag = 0, e_out = 0, e_tick = 0;

  function automatic int unsigned clampv(input int unsigned v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    m_len = 4; m_pos = 0; m_pend = 0;
    m_run = 0; m_pflag = 0; e_out = 0; e_tick = 0;
  endtask

  always @(posedge rst) model_reset();

  always @(posedge clk) begin
    bit new_period;
    int unsigned h;
    if (rst) begin
      model_reset();
    end else begin
      new_period = 0;
      if (!m_run) begin
        new_period = en;
      end else if (m_pos == m_len - 1) begin
        if (en) new_period = 1;
        else begin
          if (m_pflag) begin m_len = m_pend; m_pflag = 0; end
          m_run = 0; m_pos = 0;
        end
      end else begin
        m_pos++;
      end
      if (new_period) begin
        if (m_pflag) begin m_len = m_pend; m_pflag = 0; end
        m_run = 1; m_pos = 0;
      end
      if (load) begin m_pend = clampv(int'(div_val)); m_pflag = 1; end
      h = mode ? 1 : m_len / 2;
      e_tick = new_period;
      e_out  = m_run && (m_pos < h);
    end
    #1;
    check("model_clk_out", 32'(clk_out), 32'(e_out));
    check("model_tick", 32'(tick), 32'(e_tick));
    check("model_pending", 32'(pending), 32'(m_pflag));
    check("model_div_active", 32'(div_active), m_len);
  end

  // Patterns are MSB-first: bit len-1 is the first edge sampled.
  task automatic expect_seq(input string name, input logic [31:0] out_pat,
                            input logic [31:0] tick_pat, input int len);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      check({name, "_clk_out"}, 32'(clk_out), 32'(out_pat[len-1-i]));
      check({name, "_tick"}, 32'(tick), 32'(tick_pat[len-1-i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_clk_out", 32'(clk_out), 0);
    check("reset_tick", 32'(tick), 0);
    check("reset_pending", 32'(pending), 0);
    check("reset_div_active", 32'(div_active), 4);
    rst = 1'b0;

    // Default N=4 square wave
    @(negedge clk); en = 1'b1;
    expect_seq("n4", 32'b11001100, 32'b10001000, 8);

    // Mid-period load of 6
    @(posedge clk); @(posedge clk);
    @(negedge clk); load = 1'b1; div_val = 8'd6;
    @(posedge clk); #1;
    check("load6_pending", 32'(pending), 1);
    check("load6_div_active_old", 32'(div_active), 4);
    @(negedge clk); load = 1'b0;
    expect_seq("n6", 32'b0111000111000, 32'b0100000100000, 13);
    check("n6_div_active", 32'(div_active), 6);
    check("n6_pending", 32'(pending), 0);

    // Enable drop in a N=6 period, then restart
    @(posedge clk);
    @(negedge clk); en = 1'b0;
    expect_seq("drop", 32'b11000000, 32'b00000000, 8);
    @(negedge clk); en = 1'b1;
    expect_seq("restart", 32'b1, 32'b1, 1);

    // N=5 square
    @(negedge clk); load = 1'b1; div_val = 8'd5;
    @(posedge clk);
    @(negedge clk); load = 1'b0;
    repeat (4) @(posedge clk);
    expect_seq("n5_sq", 32'b1100011000, 32'b1000010000, 10);

    // N=5 pulse, mode changed while idle
    @(negedge clk); en = 1'b0;
    @(posedge clk);
    @(negedge clk); mode = 1'b1; en = 1'b1;
    expect_seq("n5_pulse", 32'b1000010000, 32'b1000010000, 10);

    // Clamp of 0 to 2
    @(negedge clk); load = 1'b1; div_val = 8'd0;
    @(posedge clk); #1;
    check("clamp_pending", 32'(pending), 1);
    check("clamp_div_active_old", 32'(div_active), 5);
    @(negedge clk); load = 1'b0; mode = 1'b0;
    repeat (4) @(posedge clk);
    expect_seq("n2", 32'b1010, 32'b1010, 4);
    check("n2_div_active", 32'(div_active), 2);
    check("n2_pending", 32'(pending), 0);

    // Load exactly on a boundary cycle
    @(negedge clk); load = 1'b1; div_val = 8'd3;
    @(posedge clk); #1;
    check("bnd_pending", 32'(pending), 1);
    check("bnd_div_active_old", 32'(div_active), 2);
    @(negedge clk); load = 1'b0;
    expect_seq("n3", 32'b0100100, 32'b0100100, 7);
    check("n3_div_active", 32'(div_active), 3);

    // Asynchronous reset mid high phase
    @(negedge clk); load = 1'b1; div_val = 8'd8;
    @(posedge clk); #1;
    check("prereset_clk_out", 32'(clk_out), 1);
    check("prereset_pending", 32'(pending), 1);
    #1 rst = 1'b1;
    #1;
    check("areset_clk_out", 32'(clk_out), 0);
    check("areset_pending", 32'(pending), 0);
    check("areset_tick", 32'(tick), 0);
    check("areset_div_active", 32'(div_active), 4);
    @(negedge clk); rst = 1'b0; load = 1'b0;
    expect_seq("post_reset", 32'b11001100, 32'b10001000, 8);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
